// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding and default widths for the serial bus master and slave
package bus_pkg;

    localparam int BUS_N   = 8;
    localparam int BUS_ADN = 12;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        ADDR     = 3'd2,
        WDATA    = 3'd3,
        RDATA    = 3'd4,
        DONE     = 3'd5
    } bus_state_e;

    // One spare bit so a counter never wraps while reaching its terminal value.
    function automatic int bus_cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// rtl/bus_shift_reg.sv - index-addressed serialiser/deserialiser: parallel load, serial out at idx, serial in at idx
module bus_shift_reg #(
    parameter  int W  = 8,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_i,
    input  logic [W-1:0]  load_data_i,
    input  logic [IW-1:0] idx_i,
    input  logic          sin_en_i,
    input  logic          sin_i,
    output logic          sout_o,
    output logic [W-1:0]  data_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (sin_en_i) begin
            data_q[idx_i] <= sin_i;
        end
    end

    assign sout_o = data_q[idx_i];
    assign data_o = data_q;

endmodule

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - turns one parallel request into a bit-serial bus transaction and collects serial read data
module bus_master_port
    import bus_pkg::*;
#(
    parameter int N       = BUS_N,
    parameter int ADN     = BUS_ADN,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           req,
    input  logic           req_wren,
    input  logic [ADN-1:0] req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [N-1:0]   rdata,
    output logic           m_valid,
    output logic           m_wren,
    output logic           m_addr,
    output logic           m_wdata,
    input  logic           s_ready,
    input  logic           s_valid,
    input  logic           s_rdata
);

    localparam int CW  = bus_cnt_width((ADN > N) ? ADN : N);
    localparam int BW  = bus_cnt_width(N);
    localparam int TW  = bus_cnt_width(TIMEOUT);
    localparam int AIW = (ADN > 1) ? $clog2(ADN) : 1;
    localparam int DIW = (N > 1) ? $clog2(N) : 1;

    bus_state_e     state_q;
    logic           wren_q;
    logic [CW-1:0]  cnt_q;
    logic [BW-1:0]  bitcnt_q;
    logic [TW-1:0]  to_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic           m_valid_q;
    logic           m_wren_q;
    logic [N-1:0]   rdata_q;

    logic           accept;
    logic           rd_cap;
    logic           addr_bit;
    logic           wdata_bit;
    logic           rd_sout;
    logic [ADN-1:0] addr_all;
    logic [N-1:0]   wdata_all;
    logic [N-1:0]   rd_sh;
    logic [N-1:0]   rd_word;
    logic           unused_sigs;

    assign accept = (state_q == IDLE) && req;
    assign rd_cap = (state_q == RDATA) && s_valid;

    bus_shift_reg #(.W(ADN)) u_addr_sr (
        .clk         (clk),
        .rstn        (rstn),
        .load_i      (accept),
        .load_data_i (req_addr),
        .idx_i       (cnt_q[AIW-1:0]),
        .sin_en_i    (1'b0),
        .sin_i       (1'b0),
        .sout_o      (addr_bit),
        .data_o      (addr_all)
    );

    bus_shift_reg #(.W(N)) u_wdata_sr (
        .clk         (clk),
        .rstn        (rstn),
        .load_i      (accept),
        .load_data_i (req_wdata),
        .idx_i       (cnt_q[DIW-1:0]),
        .sin_en_i    (1'b0),
        .sin_i       (1'b0),
        .sout_o      (wdata_bit),
        .data_o      (wdata_all)
    );

    bus_shift_reg #(.W(N)) u_rdata_sr (
        .clk         (clk),
        .rstn        (rstn),
        .load_i      (1'b0),
        .load_data_i ('0),
        .idx_i       (bitcnt_q[DIW-1:0]),
        .sin_en_i    (rd_cap),
        .sin_i       (s_rdata),
        .sout_o      (rd_sout),
        .data_o      (rd_sh)
    );

    assign unused_sigs = ^{addr_all, wdata_all, rd_sout};

    // The last bit lands in the shift register on the same edge rdata is loaded, so merge it here.
    always_comb begin
        rd_word        = rd_sh;
        rd_word[N-1]   = s_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            wren_q    <= 1'b0;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            to_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_wren_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q  <= WAIT_RDY;
                        busy_q   <= 1'b1;
                        wren_q   <= req_wren;
                        cnt_q    <= '0;
                        bitcnt_q <= '0;
                        to_q     <= '0;
                    end
                end
                WAIT_RDY: begin
                    if (s_ready) begin
                        state_q   <= ADDR;
                        m_valid_q <= 1'b1;
                        m_wren_q  <= wren_q;
                    end
                end
                ADDR: begin
                    if (cnt_q == CW'(ADN - 1)) begin
                        cnt_q <= '0;
                        if (wren_q) begin
                            state_q <= WDATA;
                        end else begin
                            state_q   <= RDATA;
                            m_valid_q <= 1'b0;
                            m_wren_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WDATA: begin
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_q     <= '0;
                        state_q   <= DONE;
                        m_valid_q <= 1'b0;
                        m_wren_q  <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RDATA: begin
                    if (s_valid) begin
                        to_q <= '0;
                        if (bitcnt_q == BW'(N - 1)) begin
                            bitcnt_q <= '0;
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            rdata_q  <= rd_word;
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end else if (to_q == TW'(TIMEOUT - 1)) begin
                        to_q    <= '0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign m_valid = m_valid_q;
    assign m_wren  = m_wren_q;
    assign m_addr  = (state_q == ADDR) && addr_bit;
    assign m_wdata = (state_q == WDATA) && wdata_bit;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - self-checking bench for bus_master_port with a cycle-level transaction model
module tb_bus_master_port;

    localparam int N   = 8;
    localparam int ADN = 12;
    localparam int TMO = 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic           req;
    logic           req_wren;
    logic [ADN-1:0] req_addr;
    logic [N-1:0]   req_wdata;
    logic           busy;
    logic           done;
    logic           err;
    logic [N-1:0]   rdata;
    logic           m_valid;
    logic           m_wren;
    logic           m_addr;
    logic           m_wdata;
    logic           s_ready;
    logic           s_valid;
    logic           s_rdata;

    int           n_total = 0;
    int           n_bad   = 0;
    logic [N-1:0] exp_rdata = '0;
    logic [6:0]   out_vec;

    bus_master_port #(.N(N), .ADN(ADN), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_wren  (req_wren),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_wren    (m_wren),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .s_ready   (s_ready),
        .s_valid   (s_valid),
        .s_rdata   (s_rdata)
    );

    always #5 clk = ~clk;

    assign out_vec = {busy, done, err, m_valid, m_wren, m_addr, m_wdata};

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req       = 1'b0;
            req_wren  = 1'($urandom);
            req_addr  = ADN'($urandom);
            req_wdata = N'($urandom);
            s_ready   = 1'($urandom);
            s_valid   = 1'($urandom);
            s_rdata   = 1'($urandom);
            @(posedge clk); #1;
            expect_eq("idle_out", 32'(out_vec), 32'd0);
            expect_eq("idle_rdata", 32'(rdata), 32'(exp_rdata));
        end
    endtask

    // vpat bit j = slave s_valid in the j-th cycle after the address phase ends.
    task automatic run_txn(input logic wr, input logic [ADN-1:0] a, input logic [N-1:0] wd,
                           input int dly, input logic [N-1:0] rw, input logic [63:0] vpat,
                           input int abort_c);
        int         a0, r0, dc, bits, z, sent;
        logic       e;
        logic [6:0] exp_o;
        a0   = dly + 2;
        r0   = a0 + ADN;
        dc   = a0 + ADN + N;
        e    = 1'b0;
        sent = 0;
        if (!wr) begin
            bits = 0;
            z    = 0;
            dc   = -1;
            for (int j = 0; j < 64 && dc < 0; j++) begin
                if (vpat[j]) begin
                    z = 0;
                    bits++;
                    if (bits == N) dc = r0 + j + 1;
                end else begin
                    z++;
                    if (z == TMO) begin
                        dc = r0 + j + 1;
                        e  = 1'b1;
                    end
                end
            end
        end
        req       = 1'b1;
        req_wren  = wr;
        req_addr  = a;
        req_wdata = wd;
        for (int c = 1; c <= dc + 1; c++) begin
            @(posedge clk); #1;
            exp_o    = '0;
            exp_o[6] = (c <= dc);
            if (c >= a0 && c < a0 + ADN) begin
                exp_o[3] = 1'b1;
                exp_o[2] = wr;
                exp_o[1] = a[c - a0];
            end else if (wr && c >= a0 + ADN && c < dc) begin
                exp_o[3] = 1'b1;
                exp_o[2] = 1'b1;
                exp_o[0] = wd[c - a0 - ADN];
            end
            if (c == dc) begin
                exp_o[5] = 1'b1;
                exp_o[4] = e;
                if (!wr && !e) exp_rdata = rw;
            end
            expect_eq("bus_out", 32'(out_vec), 32'(exp_o));
            expect_eq("rdata", 32'(rdata), 32'(exp_rdata));
            if (c == abort_c) begin
                rstn = 1'b0;
                req  = 1'b0;
                @(posedge clk); #1;
                exp_rdata = '0;
                expect_eq("rst_out", 32'(out_vec), 32'd0);
                expect_eq("rst_rdata", 32'(rdata), 32'd0);
                rstn = 1'b1;
                return;
            end
            req       = 1'($urandom);
            req_wren  = 1'($urandom);
            req_addr  = ADN'($urandom);
            req_wdata = N'($urandom);
            if (c <= dly) s_ready = 1'b0;
            else if (c == dly + 1) s_ready = 1'b1;
            else s_ready = 1'($urandom);
            if (!wr && c >= r0 && c < dc) begin
                s_valid = vpat[c - r0];
                if (s_valid && sent < N) begin
                    s_rdata = rw[sent];
                    sent++;
                end else begin
                    s_rdata = 1'($urandom);
                end
            end else begin
                s_valid = 1'($urandom);
                s_rdata = 1'($urandom);
            end
        end
        req = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        req       = 1'b0;
        req_wren  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        s_ready   = 1'b0;
        s_valid   = 1'b0;
        s_rdata   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("reset_out", 32'(out_vec), 32'd0);
        expect_eq("reset_rdata", 32'(rdata), 32'd0);
        rstn = 1'b1;
        idle(2);

        run_txn(1'b1, 12'hA5C, 8'h3B, 0, 8'h00, 64'd0, 0);
        run_txn(1'b0, 12'h123, 8'h00, 0, 8'h96, 64'hF78, 0);
        run_txn(1'b0, 12'h3C1, 8'h00, 0, 8'h5A, 64'd0, 0);
        idle(1);
        run_txn(1'b1, 12'h0F0, 8'hC3, 10, 8'h00, 64'd0, 0);
        run_txn(1'b1, 12'h555, 8'hAA, 0, 8'h00, 64'd0, 6);
        run_txn(1'b1, 12'hABC, 8'h12, 0, 8'h00, 64'd0, 0);
        run_txn(1'b0, 12'h0FF, 8'h00, 1, 8'hE1, 64'hFFFF, 0);

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), ADN'($urandom), N'($urandom), int'($urandom_range(0, 3)),
                    N'($urandom), {$urandom, $urandom} | {$urandom, $urandom}, 0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Upstream neighbour of the serial bus slave. Converts one parallel request from a local requester into the bit-serial bus protocol: valid, wren, serial address, serial write data.
- For reads, deserialises the slave's serial read data back into a parallel word.
- Sits between the master-side requester logic and the bus interconnect/slave; one outstanding transaction at a time.

Parameters:
- N, 8, data word width (bits per serial data phase).
- ADN, 12, address width (bits per serial address phase).
- TIMEOUT, 255, max cycles waited for slave read data (s_valid) before abort; minimum 1.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rstn  in  1  synchronous, active-low reset.
- req  in  1  request strobe; sampled only when busy=0.
- req_wren  in  1  1=write, 0=read; captured with req.
- req_addr  in  ADN  target address; captured with req.
- req_wdata  in  N  write data; captured with req (ignored for reads).
- busy  out  1  high from the cycle after an accepted req until the cycle after done.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when a read timed out.
- rdata  out  N  read word; valid when done=1 and err=0; held until next accepted read.
- m_valid  out  1  to slave validIn; high during address and write-data phases.
- m_wren  out  1  to slave wren; held stable while m_valid=1.
- m_addr  out  1  to slave Address; serial address bit, LSB first.
- m_wdata  out  1  to slave DataIn; serial write bit, LSB first.
- s_ready  in  1  slave ready; slave can accept a new transaction.
- s_valid  in  1  slave validOut; qualifies each read data bit.
- s_rdata  in  1  slave DataOut; serial read bit, LSB first.

Behaviour:
- Reset (rstn=0 at an edge): state=IDLE, counters=0, all outputs 0, rdata=0. Takes priority over everything, including mid-transaction. m_valid is low from the next edge; the slave recovers via its own reset.
- States: IDLE, WAIT_RDY, ADDR, WDATA, RDATA, DONE.
- IDLE: busy=0. req=1 captures req_wren, req_addr and req_wdata into registers, then moves to WAIT_RDY.
- WAIT_RDY: m_valid=0. Moves to ADDR on the first edge where s_ready=1. Waits indefinitely otherwise.
- ADDR: ADN cycles. m_valid=1, m_wren=captured wren, m_addr=addr_reg[cnt] for cnt=0..ADN-1.
  - At cnt=ADN-1: goes to WDATA if write, RDATA if read. cnt clears.
- WDATA: N cycles. m_valid=1, m_wdata=wdata_reg[cnt], cnt=0..N-1. At cnt=N-1 goes to DONE.
- RDATA: m_valid=0.
  - Each cycle with s_valid=1: shift s_rdata into rdata_sh[bitcnt], bitcnt++.
  - When the N-th bit is captured, goes to DONE and loads rdata.
  - Timeout counter increments on every RDATA cycle with s_valid=0 and resets on s_valid=1.
  - When timeout reaches TIMEOUT, goes to DONE with err=1; rdata is unchanged.
- DONE: done=1 (and err if timed out) for exactly one cycle, then IDLE. busy=1 in DONE.
- m_addr and m_wdata are 0 whenever they are not in their own phase. m_wren is 0 outside ADDR/WDATA.
- req while busy=1 is ignored; it is not queued.
- Write latency with s_ready=1: req at edge 0, then ADDR cycles 2..ADN+1, WDATA ADN+2..ADN+N+1, done at cycle ADN+N+2 (22 with defaults).
- Counter widths: $clog2 of the largest count + 1; no wrap within a phase.

Decomposition:
- Shared package bus_pkg: state enum (IDLE, WAIT_RDY, ADDR, WDATA, RDATA, DONE) plus default N/ADN constants, shared with the slave.
- One natural sub-module: bus_shift_reg (parameterised width; serial-out with index and serial-in with enable), instantiated for address/write data out and read data in.

Test Plan:
- Write, s_ready=1, req_addr=0xA5C, req_wdata=0x3B.
  - m_addr sequence LSB first: 0,0,1,1,1,0,1,0,0,1,0,1.
  - m_wdata: 1,1,0,1,1,1,0,0.
  - m_valid high for 20 consecutive cycles; done at cycle 22, err=0.
- Read at 0x123; slave asserts s_valid 3 cycles after ADDR ends and sends 0x96 LSB first with one s_valid=0 gap mid-word.
  - Response: rdata=0x96, done=1, err=0; m_valid low throughout RDATA.
- Read with TIMEOUT=4 and s_valid never high.
  - Response: done=1, err=1 exactly 4 cycles into RDATA; rdata keeps its previous value.
- s_ready held 0 for 10 cycles after req.
  - Response: stays in WAIT_RDY with m_valid=0; ADDR starts the cycle after s_ready rises.
- Second req pulse (different addr) asserted during WDATA.
  - Response: ignored; bus shows only the first transaction; no second done.
- rstn=0 for one edge at ADDR cycle 5.
  - Response: next cycle all outputs 0, busy=0. A new req afterwards completes normally.
